// File: rtl/fpm_pkg.sv
// fpm_pkg: flag bit positions and exponent/pattern helpers shared by the multiplier.
package fpm_pkg;
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_NX = 0;
  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction
  function automatic logic [63:0] qnan_pat(input int ew, input int mw);
    return (((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1));
  endfunction
  function automatic logic [63:0] max_finite_pat(input int ew, input int mw);
    return (((64'd1 << ew) - 64'd2) << mw) | ((64'd1 << mw) - 64'd1);
  endfunction
endpackage

// File: rtl/fpm_round.sv
// fpm_round: round-to-nearest-even of a normalised significand given guard/round/sticky.
module fpm_round #(
  parameter int MAN_W = 23
) (
  input  logic [MAN_W:0]   sig,
  input  logic             g,
  input  logic             r,
  input  logic             s,
  output logic [MAN_W-1:0] frac,
  output logic             carry,
  output logic             inexact
);
  logic [MAN_W+1:0] sum;
  assign sum = {1'b0, sig} + {{(MAN_W+1){1'b0}}, g & (r | s | sig[0])};
  assign carry = sum[MAN_W+1];
  assign frac = carry ? sum[MAN_W:1] : sum[MAN_W-1:0];
  assign inexact = g | r | s;
endmodule

// File: rtl/fpm_pipe.sv
// fpm_pipe: 3-stage pipelined RNE float multiplier, valid/ready on both sides, async active-low rst.
// Define FPM_SPECIAL_EN to decode Inf/NaN and overflow to Inf; otherwise overflow saturates to max finite.
module fpm_pipe
  import fpm_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int MAGW = EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int XW = EXP_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic signed [XW-1:0] BIAS = XW'(bias(EXP_W));
  localparam logic signed [XW-1:0] OVF_E = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = W'(qnan_pat(EXP_W, MAN_W));
`ifdef FPM_SPECIAL_EN
  localparam logic [MAGW-1:0] OVF_MAG = {EMAX, {MAN_W{1'b0}}};
`else
  localparam logic [MAGW-1:0] OVF_MAG = MAGW'(max_finite_pat(EXP_W, MAN_W));
`endif
  logic v1, v2, v3, en1, en2, en3;
  assign en3 = ~v3 | out_ready;
  assign en2 = ~v2 | en3;
  assign en1 = ~v1 | en2;
  assign in_ready = en1;
  assign out_valid = v3;
  logic sa1, sb1;
  logic [EXP_W-1:0] ea1, eb1;
  logic [SW-1:0] ma1, mb1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v1 <= 1'b0;
      sa1 <= 1'b0;
      sb1 <= 1'b0;
      ea1 <= '0;
      eb1 <= '0;
      ma1 <= '0;
      mb1 <= '0;
    end else if (en1) begin
      v1 <= in_valid;
      sa1 <= a[W-1];
      sb1 <= b[W-1];
      ea1 <= a[W-2 -: EXP_W];
      eb1 <= b[W-2 -: EXP_W];
      ma1 <= {a[W-2 -: EXP_W] != '0, a[MAN_W-1:0]};
      mb1 <= {b[W-2 -: EXP_W] != '0, b[MAN_W-1:0]};
    end
  logic za, zb, ia, ib, na, nb;
  assign za = ea1 == '0;
  assign zb = eb1 == '0;
`ifdef FPM_SPECIAL_EN
  assign ia = ea1 == EMAX && ma1[MAN_W-1:0] == '0;
  assign ib = eb1 == EMAX && mb1[MAN_W-1:0] == '0;
  assign na = ea1 == EMAX && ma1[MAN_W-1:0] != '0;
  assign nb = eb1 == EMAX && mb1[MAN_W-1:0] != '0;
`else
  assign ia = 1'b0;
  assign ib = 1'b0;
  assign na = 1'b0;
  assign nb = 1'b0;
`endif
  logic s2, z2, i2, n2;
  logic signed [XW-1:0] x2;
  logic [PW-1:0] p2;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v2 <= 1'b0;
      s2 <= 1'b0;
      z2 <= 1'b0;
      i2 <= 1'b0;
      n2 <= 1'b0;
      x2 <= '0;
      p2 <= '0;
    end else if (en2) begin
      v2 <= v1;
      s2 <= sa1 ^ sb1;
      z2 <= za | zb;
      i2 <= ia | ib;
      n2 <= na | nb | (ia & zb) | (ib & za);
      x2 <= $signed({2'b00, ea1}) + $signed({2'b00, eb1}) - BIAS;
      p2 <= PW'(ma1) * PW'(mb1);
    end
  // Normalise so the leading one sits at the top; the exponent absorbs a product >= 2.
  logic [PW-1:0] q;
  logic signed [XW-1:0] x_n, x_f;
  logic [MAN_W-1:0] frac_r;
  logic carry, nx, fin, ovf, unf;
  assign q = p2[PW-1] ? p2 : p2 << 1;
  assign x_n = x2 + $signed({{(XW-1){1'b0}}, p2[PW-1]});
  fpm_round #(.MAN_W(MAN_W)) u_round (
    .sig(q[PW-1 -: SW]),
    .g(q[PW-SW-1]),
    .r(q[PW-SW-2]),
    .s(|q[PW-SW-3:0]),
    .frac(frac_r),
    .carry(carry),
    .inexact(nx)
  );
  assign x_f = x_n + $signed({{(XW-1){1'b0}}, carry});
  assign fin = ~n2 & ~i2 & ~z2;
  assign ovf = fin & (x_f >= OVF_E);
  assign unf = fin & (x_f[XW-1] | x_f == '0);
  logic [W-1:0] res_d;
  logic [3:0] flg_d;
  assign res_d = n2 ? QNAN : i2 ? {s2, EMAX, {MAN_W{1'b0}}} : (z2 | unf) ? {s2, {MAGW{1'b0}}} :
                 ovf ? {s2, OVF_MAG} : {s2, x_f[EXP_W-1:0], frac_r};
  always_comb begin
    flg_d = '0;
    flg_d[FLG_INV] = n2;
    flg_d[FLG_OVF] = ovf;
    flg_d[FLG_UNF] = unf;
    flg_d[FLG_NX] = fin & (ovf | unf | nx);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v3 <= 1'b0;
      result <= '0;
      flags <= '0;
    end else if (en3) begin
      v3 <= v2;
      result <= res_d;
      flags <= flg_d;
    end
endmodule

// File: tb/tb_fpm_pipe.sv
// tb_fpm_pipe: directed and randomized checks of fpm_pipe against a remainder-based RNE reference model.
module tb_fpm_pipe;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [31:0] a = '0, b = '0, result;
  logic [3:0] flags;
  int tests = 0, fails = 0;
  logic [35:0] exp_q[$];
  logic held = 1'b0;
  logic [35:0] held_v;
  logic done = 1'b0;
  int lat;
  logic [31:0] da [6] = '{32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h00800000, 32'h7F800000, 32'h7FC00001};
  logic [31:0] db [6] = '{32'hC0200000, 32'h3F800001, 32'h40000000, 32'h3F000000, 32'h00000000, 32'h3F800000};
`ifdef FPM_SPECIAL_EN
  localparam logic [30:0] OVF_MAG = 31'h7F800000;
`else
  localparam logic [30:0] OVF_MAG = 31'h7F7FFFFF;
`endif

  always #5 clk = ~clk;

  fpm_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  // Returns {invalid, overflow, underflow, inexact, result}.
  function automatic logic [35:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic s, nx;
    int ex, ey, e, sh;
    logic [63:0] p, sig, rem, half;
    s = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
`ifdef FPM_SPECIAL_EN
    begin
      logic xn, yn, xi, yi;
      xn = ex == 255 && x[22:0] != 0;
      yn = ey == 255 && y[22:0] != 0;
      xi = ex == 255 && x[22:0] == 0;
      yi = ey == 255 && y[22:0] == 0;
      if (xn || yn || (xi && ey == 0) || (yi && ex == 0)) return {4'b1000, 32'h7FC00000};
      if (xi || yi) return {4'b0000, s, 31'h7F800000};
    end
`endif
    if (ex == 0 || ey == 0) return {4'b0000, s, 31'b0};
    p = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
    sh = p[47] ? 24 : 23;
    e = ex + ey - 127 + (sh - 23);
    sig = p >> sh;
    rem = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    nx = rem != 0;
    if (rem > half || (rem == half && sig[0])) sig = sig + 64'd1;
    if (sig == (64'd1 << 24)) begin
      sig = sig >> 1;
      e = e + 1;
    end
    if (e >= 255) return {4'b0101, s, OVF_MAG};
    if (e <= 0) return {4'b0011, s, 31'b0};
    return {3'b000, nx, s, 8'(e), sig[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    logic [22:0] f;
    case ($urandom_range(0, 7))
      0: e = 8'h00;
      1: e = 8'hFF;
      2: e = 8'h01;
      3: e = 8'hFE;
      default: e = 8'($urandom_range(64, 190));
    endcase
    case ($urandom_range(0, 3))
      0: f = '0;
      1: f = '1;
      default: f = 23'($urandom);
    endcase
    return {1'($urandom), e, f};
  endfunction

  task automatic check(input string name, input logic [39:0] got, input logic [39:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    logic hs;
    in_valid = 1'b1;
    a = x;
    b = y;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!hs && n < 100);
    if (!hs) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck 0 for op %h*%h", x, y);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 40'(exp_q.size()), 40'd0);
  endtask

  // Scoreboard: sample between edges, so values seen here are the ones the next edge transfers.
  always @(negedge clk) begin
    if (!rst) held = 1'b0;
    else begin
      if (held) check("hold_stable", {3'b0, out_valid, flags, result}, {4'b0001, held_v});
      if (in_valid && in_ready) exp_q.push_back(ref_mul(a, b));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_out: got %h flags %h want none", result, flags);
        end else check("result", {4'b0, flags, result}, {4'b0, exp_q.pop_front()});
      end
      held = out_valid && !out_ready;
      held_v = {flags, result};
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    #1 rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {3'b0, out_valid, flags, result}, 40'd0);
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 40'(in_ready), 40'd1);
    @(posedge clk);
    #1;
    check("m_3x2", 40'(ref_mul(32'h40400000, 32'h40000000)), {8'h0, 32'h40C00000});
    check("m_neg", 40'(ref_mul(32'h3FC00000, 32'hC0200000)), {8'h0, 32'hC0700000});
    check("m_ulp", 40'(ref_mul(32'h3F800001, 32'h3F800001)), {8'h1, 32'h3F800002});
    check("m_ovf", 40'(ref_mul(32'h7F000000, 32'h40000000)), {8'h5, 1'b0, OVF_MAG});
    check("m_unf", 40'(ref_mul(32'h00800000, 32'h3F000000)), {8'h3, 32'h00000000});
`ifdef FPM_SPECIAL_EN
    check("m_inv", 40'(ref_mul(32'h7F800000, 32'h00000000)), {8'h8, 32'h7FC00000});
`else
    check("m_infzero", 40'(ref_mul(32'h7F800000, 32'h00000000)), {8'h0, 32'h00000000});
`endif
    send(32'h40400000, 32'h40000000);
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 10);
    check("latency", 40'(lat), 40'd3);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) send(da[i], db[i]);
    in_valid = 1'b0;
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h3F800000 + 32'(i), 32'h40400000);
    a = 32'h3F800003;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("in_ready_full", 40'(in_ready), 40'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(32'h3F800003, 32'h40400000);
    in_valid = 1'b0;
    drain();
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send(rand_op(), rand_op());
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = $urandom_range(0, 3) != 0;
        end
      end
    join
    out_ready = 1'b1;
    drain();
    out_ready = 1'b0;
    send(32'h40400000, 32'h40000000);
    send(32'h3FC00000, 32'h40000000);
    in_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid", {3'b0, out_valid, flags, result}, 40'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("in_ready_post_rst", 40'(in_ready), 40'd1);
    repeat (10) @(posedge clk);
    #1;
    send(32'h3F800001, 32'h3F800001);
    in_valid = 1'b0;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
